ppu_vram_ctrl: RTL and testbench

- Serves the PPU's memory-access port (read/write request handshake, 14-bit PPU address space).
- Decodes each access to one of three targets:
  - CHR space ($0000-$1FFF), forwarded to an external cartridge-side port with a ready handshake.
  - Internal 2 KB nametable RAM ($2000-$3EFF), with selectable mirroring.
  - Internal 32-entry palette RAM ($3F00-$3FFF).
- Sits directly downstream of ppu_top's ppu_mem_* interface, in the PPU clock domain.

---
 rtl/nes_ppu_pkg.sv | 57 +++++
 rtl/ppu_vram_ctrl_if.sv | 22 ++
 rtl/ppu_nt_ram.sv | 25 ++
 rtl/ppu_vram_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_ppu_vram_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nes_ppu_pkg.sv
// Shared PPU definitions: mirroring codes, address-region bases, the VRAM FSM state type
// and the address-to-RAM-index helpers used by the VRAM controller.
package nes_ppu_pkg;

  localparam logic [1:0] MIR_HORIZ    = 2'b00;
  localparam logic [1:0] MIR_VERT     = 2'b01;
  localparam logic [1:0] MIR_SINGLE_A = 2'b10;
  localparam logic [1:0] MIR_SINGLE_B = 2'b11;

  localparam logic [13:0] CHR_END  = 14'h1FFF;
  localparam logic [13:0] PAL_BASE = 14'h3F00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NT_ACC,
    ST_PAL_ACC,
    ST_CHR_WAIT,
    ST_DONE
  } vram_state_e;

  // State an access to this address enters right after it is accepted.
  function automatic vram_state_e access_state(input logic [13:0] a);
    if (a <= CHR_END) begin
      return ST_CHR_WAIT;
    end else if (a[13:8] == PAL_BASE[13:8]) begin
      return ST_PAL_ACC;
    end
    return ST_NT_ACC;
  endfunction

  // $3F10/14/18/1C share storage with $3F00/04/08/0C.
  function automatic logic [4:0] pal_index(input logic [4:0] a);
    logic [4:0] idx;
    idx = a;
    if (a[1:0] == 2'b00) begin
      idx[4] = 1'b0;
    end
    return idx;
  endfunction

  // Only addr[11:0] matters, so $3000-$3EFF lands on the same cells as $2000-$2EFF.
  function automatic logic [11:0] nt_index(input logic [11:0] a, input logic [1:0] mode,
                                           input logic four_screen);
    logic page;
    if (four_screen) begin
      return a;
    end
    case (mode)
      MIR_HORIZ:    page = a[11];
      MIR_VERT:     page = a[10];
      MIR_SINGLE_A: page = 1'b0;
      default:      page = 1'b1;
    endcase
    return {1'b0, page, a[9:0]};
  endfunction

endpackage

// File: rtl/ppu_vram_ctrl_if.sv
// PPU-side memory-access bus: request pulses, address/data and the completion handshake.
// The PPU core is the master and the VRAM controller is the slave.
interface ppu_vram_ctrl_if;
  logic        req_rd;
  logic        req_wr;
  logic [13:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        ack;
  logic        busy;
  logic        err;

  modport master (
    output req_rd, req_wr, addr, din,
    input  dout, ack, busy, err
  );

  modport slave (
    input  req_rd, req_wr, addr, din,
    output dout, ack, busy, err
  );
endinterface

// File: rtl/ppu_nt_ram.sv
// Single-port nametable RAM, 8 bits wide, 2^AW deep, with one cycle of registered read
// latency so that it maps onto a block RAM.
module ppu_nt_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:(1<<AW)-1];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ppu_vram_ctrl.sv
// PPU VRAM controller: routes each PPU access to CHR (external port), nametable RAM or palette.
// Define VRAM_FOUR_SCREEN_EN for a 4 KB nametable and the i_four_screen override input.
module ppu_vram_ctrl
  import nes_ppu_pkg::*;
#(
  parameter int CHR_TIMEOUT = 64,
  parameter int NT_AW       = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  ppu_vram_ctrl_if.slave        ppu_bus,
  input  logic [1:0]            i_mirror_mode,
`ifdef VRAM_FOUR_SCREEN_EN
  input  logic                  i_four_screen,
`endif
  output logic [12:0]           o_chr_addr,
  output logic                  o_chr_rd,
  output logic                  o_chr_wr,
  output logic [7:0]            o_chr_wdata,
  input  logic [7:0]            i_chr_rdata,
  input  logic                  i_chr_ready
);

`ifdef VRAM_FOUR_SCREEN_EN
  localparam int RAM_AW = NT_AW + 1;
`else
  localparam int RAM_AW = NT_AW;
`endif
  localparam logic [7:0] WAIT_LAST = 8'(CHR_TIMEOUT - 1);

  vram_state_e r_state;
  vram_state_e w_state_next;
  vram_state_e w_target;

  logic [13:0]       r_addr;
  logic [7:0]        r_din;
  logic              r_op_wr;
  logic [7:0]        r_dout;
  logic              r_chr_rd;
  logic              r_chr_wr;
  logic [7:0]        r_wait;
  logic              r_err;
  logic [5:0]        r_pal [0:31];

  logic              w_req;
  logic              w_accept;
  logic              w_ack;
  logic              w_busy;
  logic              w_timeout;
  logic              w_four;
  logic [11:0]       w_nt_idx_full;
  logic [RAM_AW-1:0] w_nt_idx;
  logic [7:0]        w_nt_rdata;
  logic              w_nt_we;
  logic              w_nt_rd_done;
  logic [4:0]        w_pal_idx;
  logic [5:0]        w_pal_rdata;

`ifdef VRAM_FOUR_SCREEN_EN
  assign w_four = i_four_screen;
`else
  assign w_four = 1'b0;
`endif

  assign w_req         = ppu_bus.req_rd | ppu_bus.req_wr;
  assign w_target      = access_state(ppu_bus.addr);
  assign w_nt_idx_full = nt_index(r_addr[11:0], i_mirror_mode, w_four);
  assign w_nt_idx      = RAM_AW'(w_nt_idx_full);
  assign w_pal_idx     = pal_index(r_addr[4:0]);
  assign w_pal_rdata   = r_pal[w_pal_idx];
  assign w_nt_we       = (r_state == ST_NT_ACC) && r_op_wr;
  assign w_nt_rd_done  = (r_state == ST_DONE) && !r_op_wr && (access_state(r_addr) == ST_NT_ACC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Writes to RAM/palette acknowledge in their single access cycle; every ack cycle doubles
  // as an idle cycle so a new request can be taken without a bubble.
  always_comb begin
    w_state_next = r_state;
    w_ack        = 1'b0;
    w_busy       = 1'b0;
    w_timeout    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_NT_ACC, ST_PAL_ACC: begin
        if (r_op_wr) begin
          w_ack = 1'b1;
        end else begin
          w_busy       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_CHR_WAIT: begin
        w_busy = 1'b1;
        if (i_chr_ready) begin
          w_state_next = ST_DONE;
        end else if (r_wait == WAIT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_ack = 1'b1;
      default: w_state_next = ST_IDLE;
    endcase
    w_accept = w_req && !w_busy;
    if (w_accept) begin
      w_state_next = w_target;
    end else if (w_ack) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_din    <= '0;
      r_op_wr  <= 1'b0;
      r_dout   <= '0;
      r_chr_rd <= 1'b0;
      r_chr_wr <= 1'b0;
      r_wait   <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_PAL_ACC: begin
          if (!r_op_wr) begin
            r_dout <= {2'b00, w_pal_rdata};
          end
        end
        ST_CHR_WAIT: begin
          if (i_chr_ready) begin
            r_chr_rd <= 1'b0;
            r_chr_wr <= 1'b0;
            if (!r_op_wr) begin
              r_dout <= i_chr_rdata;
            end
          end else if (w_timeout) begin
            r_chr_rd <= 1'b0;
            r_chr_wr <= 1'b0;
            r_err    <= 1'b1;
            if (!r_op_wr) begin
              r_dout <= 8'hFF;
            end
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_DONE: begin
          r_err <= 1'b0;
          // Keep the nametable read value on dout after the ack cycle.
          if (w_nt_rd_done) begin
            r_dout <= w_nt_rdata;
          end
        end
        default: ;
      endcase
      if (w_accept) begin
        r_addr   <= ppu_bus.addr;
        r_din    <= ppu_bus.din;
        r_op_wr  <= ppu_bus.req_wr;
        r_wait   <= '0;
        r_chr_rd <= (w_target == ST_CHR_WAIT) && !ppu_bus.req_wr;
        r_chr_wr <= (w_target == ST_CHR_WAIT) && ppu_bus.req_wr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == ST_PAL_ACC) && r_op_wr) begin
      r_pal[w_pal_idx] <= r_din[5:0];
    end
  end

  ppu_nt_ram #(
    .AW(RAM_AW)
  ) u_nt_ram (
    .clk     (clk),
    .i_we    (w_nt_we),
    .i_addr  (w_nt_idx),
    .i_wdata (r_din),
    .o_rdata (w_nt_rdata)
  );

  assign ppu_bus.dout = w_nt_rd_done ? w_nt_rdata : r_dout;
  assign ppu_bus.ack  = w_ack;
  assign ppu_bus.busy = w_busy;
  assign ppu_bus.err  = (r_state == ST_DONE) && r_err;

  assign o_chr_addr  = r_addr[12:0];
  assign o_chr_wdata = r_din;
  assign o_chr_rd    = r_chr_rd;
  assign o_chr_wr    = r_chr_wr;

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// Directed bench for ppu_vram_ctrl: a vector table for nametable/palette accesses plus
// hand-written CHR, timeout, busy, back-to-back and reset sequences.
module tb_ppu_vram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mirror_mode;
  logic [12:0] chr_addr;
  logic        chr_rd;
  logic        chr_wr;
  logic [7:0]  chr_wdata;
  logic [7:0]  chr_rdata;
  logic        chr_ready;

  int total = 0;
  int bad   = 0;

  ppu_vram_ctrl_if bus ();

  ppu_vram_ctrl #(
    .CHR_TIMEOUT (64),
    .NT_AW       (11)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ppu_bus       (bus),
    .i_mirror_mode (mirror_mode),
`ifdef VRAM_FOUR_SCREEN_EN
    .i_four_screen (1'b0),
`endif
    .o_chr_addr    (chr_addr),
    .o_chr_rd      (chr_rd),
    .o_chr_wr      (chr_wr),
    .o_chr_wdata   (chr_wdata),
    .i_chr_rdata   (chr_rdata),
    .i_chr_ready   (chr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [7:0]  din;
    logic [1:0]  mm;
    int          lat;
    logic [7:0]  dout;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One access starting at the next negedge; lat counts cycles from the accept cycle to ack.
  task automatic access(input logic wr, input logic [13:0] a, input logic [7:0] d,
                        input int rdy_at, input logic [7:0] rdata,
                        output int lat, output logic [7:0] q, output logic e,
                        output logic bz, output logic stb, output int nstb,
                        output logic stb_ok);
    @(negedge clk);
    bus.req_rd = !wr;
    bus.req_wr = wr;
    bus.addr   = a;
    bus.din    = d;
    @(negedge clk);
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
    lat    = 1;
    nstb   = 0;
    stb_ok = 1'b1;
    while (bus.ack !== 1'b1 && lat < 200) begin
      if (chr_rd || chr_wr) begin
        nstb++;
        if (chr_addr !== a[12:0] || chr_rd !== !wr || chr_wr !== wr || (wr && chr_wdata !== d))
          stb_ok = 1'b0;
        chr_ready = (nstb == rdy_at);
        chr_rdata = rdata;
      end
      @(negedge clk);
      chr_ready = 1'b0;
      lat++;
    end
    if (lat >= 200) lat = -1;
    q   = bus.dout;
    e   = bus.err;
    bz  = bus.busy;
    stb = chr_rd | chr_wr;
  endtask

  int         lat;
  int         nstb;
  int         acks;
  logic [7:0] q;
  logic [7:0] exp_last;
  logic       e;
  logic       bz;
  logic       stb;
  logic       stb_ok;

  initial begin
    vecs[0]  = '{1'b1, 14'h2405, 8'h11, 2'b01, 1, 8'h00};
    vecs[1]  = '{1'b1, 14'h2005, 8'hA5, 2'b01, 1, 8'h00};
    vecs[2]  = '{1'b0, 14'h2805, 8'h00, 2'b01, 2, 8'hA5};
    vecs[3]  = '{1'b0, 14'h2405, 8'h00, 2'b01, 2, 8'h11};
    vecs[4]  = '{1'b0, 14'h2405, 8'h00, 2'b00, 2, 8'hA5};
    vecs[5]  = '{1'b0, 14'h2C05, 8'h00, 2'b10, 2, 8'hA5};
    vecs[6]  = '{1'b0, 14'h2005, 8'h00, 2'b11, 2, 8'h11};
    vecs[7]  = '{1'b1, 14'h3F10, 8'hFF, 2'b00, 1, 8'h00};
    vecs[8]  = '{1'b0, 14'h3F00, 8'h00, 2'b00, 2, 8'h3F};
    vecs[9]  = '{1'b1, 14'h3F01, 8'h22, 2'b00, 1, 8'h00};
    vecs[10] = '{1'b1, 14'h3F11, 8'h12, 2'b00, 1, 8'h00};
    vecs[11] = '{1'b0, 14'h3F01, 8'h00, 2'b00, 2, 8'h22};
    vecs[12] = '{1'b0, 14'h3F11, 8'h00, 2'b00, 2, 8'h12};
    vecs[13] = '{1'b0, 14'h3F30, 8'h00, 2'b00, 2, 8'h3F};
    vecs[14] = '{1'b1, 14'h3123, 8'h5C, 2'b00, 1, 8'h00};
    vecs[15] = '{1'b0, 14'h2123, 8'h00, 2'b00, 2, 8'h5C};
    vecs[16] = '{1'b0, 14'h3123, 8'h00, 2'b00, 2, 8'h5C};
    vecs[17] = '{1'b1, 14'h3EFF, 8'h9A, 2'b00, 1, 8'h00};
    vecs[18] = '{1'b0, 14'h2EFF, 8'h00, 2'b00, 2, 8'h9A};
    vecs[19] = '{1'b0, 14'h2EFF, 8'h00, 2'b01, 2, 8'h9A};

    rst         = 1'b1;
    bus.req_rd  = 1'b0;
    bus.req_wr  = 1'b0;
    bus.addr    = '0;
    bus.din     = '0;
    mirror_mode = 2'b00;
    chr_rdata   = '0;
    chr_ready   = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_ack", bus.ack, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_err", bus.err, 0);
    check("reset_dout", bus.dout, 0);
    check("reset_chr_rd", chr_rd, 0);
    check("reset_chr_wr", chr_wr, 0);
    check("reset_chr_addr", chr_addr, 0);
    check("reset_chr_wdata", chr_wdata, 0);
    rst = 1'b0;

    // Nametable / palette vector table; writes must leave dout at the last read value.
    exp_last = 8'h00;
    for (int i = 0; i < 20; i++) begin
      mirror_mode = vecs[i].mm;
      access(vecs[i].wr, vecs[i].addr, vecs[i].din, 0, 8'h00, lat, q, e, bz, stb, nstb, stb_ok);
      if (!vecs[i].wr) exp_last = vecs[i].dout;
      $display("vec %0d %s addr=%h mm=%0d lat=%0d dout=%h err=%0d", i,
               vecs[i].wr ? "WR" : "RD", vecs[i].addr, vecs[i].mm, lat, q, e);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_dout", i), q, exp_last);
      check($sformatf("vec%0d_err", i), e, 0);
      check($sformatf("vec%0d_busy_at_ack", i), bz, 0);
    end

    // CHR read: ready during the 3rd strobe cycle.
    access(1'b0, 14'h0ABC, 8'h00, 3, 8'h77, lat, q, e, bz, stb, nstb, stb_ok);
    $display("chr read addr=0abc lat=%0d dout=%h err=%0d strobes=%0d", lat, q, e, nstb);
    check("chr_rd_latency", lat, 4);
    check("chr_rd_dout", q, 8'h77);
    check("chr_rd_err", e, 0);
    check("chr_rd_strobes", nstb, 3);
    check("chr_rd_addr_held", stb_ok, 1);
    check("chr_rd_strobe_at_ack", stb, 0);

    // CHR write at the top of CHR space, ready in the first strobe cycle.
    access(1'b1, 14'h1FFF, 8'h3C, 1, 8'h00, lat, q, e, bz, stb, nstb, stb_ok);
    $display("chr write addr=1fff lat=%0d dout=%h strobes=%0d", lat, q, nstb);
    check("chr_wr_latency", lat, 2);
    check("chr_wr_dout_unchanged", q, 8'h77);
    check("chr_wr_strobes", nstb, 1);
    check("chr_wr_addr_data_held", stb_ok, 1);

    // CHR timeout: ready never asserted.
    access(1'b0, 14'h0100, 8'h00, 0, 8'h00, lat, q, e, bz, stb, nstb, stb_ok);
    $display("chr timeout addr=0100 lat=%0d dout=%h err=%0d strobes=%0d", lat, q, e, nstb);
    check("tmo_latency", lat, 65);
    check("tmo_dout", q, 8'hFF);
    check("tmo_err", e, 1);
    check("tmo_strobes", nstb, 64);
    check("tmo_strobe_at_ack", stb, 0);
    @(negedge clk);
    check("tmo_err_one_cycle", bus.err, 0);
    check("tmo_ack_one_cycle", bus.ack, 0);

    // Request during busy is dropped; exactly one ack.
    @(negedge clk);
    bus.req_rd = 1'b1;
    bus.addr   = 14'h0055;
    @(negedge clk);
    bus.req_rd = 1'b0;
    @(negedge clk);
    check("drop_busy_high", bus.busy, 1);
    bus.req_rd = 1'b1;
    bus.addr   = 14'h2005;
    @(negedge clk);
    bus.req_rd = 1'b0;
    check("drop_chr_addr_kept", chr_addr, 13'h0055);
    chr_rdata = 8'h5A;
    chr_ready = 1'b1;
    acks = 0;
    q    = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chr_ready = 1'b0;
      if (bus.ack === 1'b1) begin
        acks++;
        q = bus.dout;
      end
    end
    $display("busy drop: acks=%0d dout=%h", acks, q);
    check("drop_ack_count", acks, 1);
    check("drop_dout", q, 8'h5A);

    // Back-to-back: new read accepted in the write's ack cycle.
    mirror_mode = 2'b00;
    @(negedge clk);
    bus.req_wr = 1'b1;
    bus.addr   = 14'h2001;
    bus.din    = 8'h44;
    @(negedge clk);
    check("b2b_wr_ack", bus.ack, 1);
    check("b2b_wr_busy", bus.busy, 0);
    bus.req_wr = 1'b0;
    bus.req_rd = 1'b1;
    @(negedge clk);
    bus.req_rd = 1'b0;
    check("b2b_rd_no_early_ack", bus.ack, 0);
    check("b2b_rd_busy", bus.busy, 1);
    @(negedge clk);
    $display("back-to-back: ack=%0d dout=%h", bus.ack, bus.dout);
    check("b2b_rd_ack", bus.ack, 1);
    check("b2b_rd_dout", bus.dout, 8'h44);

    // Reset during CHR_WAIT aborts the access with no ack.
    @(negedge clk);
    bus.req_rd = 1'b1;
    bus.addr   = 14'h0123;
    @(negedge clk);
    bus.req_rd = 1'b0;
    @(negedge clk);
    check("rst_mid_strobe_active", chr_rd, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_chr_rd", chr_rd, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_ack", bus.ack, 0);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) acks++;
    end
    $display("reset abort: acks=%0d", acks);
    check("rst_mid_no_ack", acks, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
